// File: rtl/key_conditioner_if.sv
// rtl/key_conditioner_if.sv - key pad inputs and conditioned key outputs
// master drives the raw pads; slave is the conditioner.
interface key_conditioner_if #(
  parameter int N_KEYS = 5
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic              any_press;

  modport master (
    output key_raw,
    input  key_level,
    input  key_press,
    input  any_press
  );

  modport slave (
    input  key_raw,
    output key_level,
    output key_press,
    output any_press
  );
endinterface

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - per-key synchroniser, debouncer and press-pulse generator
// Auto-repeat on REPEAT_MASK keys is built only when KEY_AUTOREPEAT_EN is defined.
module key_conditioner #(
  parameter int                N_KEYS        = 5,
  parameter int                DEBOUNCE_CNT  = 1000000,
  parameter int                REPEAT_DELAY  = 50000000,
  parameter int                REPEAT_PERIOD = 10000000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK   = 5'b11000
) (
  input logic              clk,
  input logic              reset,
  key_conditioner_if.slave keys
);
  localparam int            DW      = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CNT - 1);

`ifdef KEY_AUTOREPEAT_EN
  localparam int            RPT_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int            RW          = $clog2(RPT_MAX) + 1;
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_MASK, REPEAT_DELAY, REPEAT_PERIOD};
`endif

  logic [N_KEYS-1:0] sync1;
  logic [N_KEYS-1:0] sync2;
  logic [N_KEYS-1:0] level;
  logic [N_KEYS-1:0] rise;
  logic [N_KEYS-1:0] rpt_pulse;
  logic [N_KEYS-1:0] press_d;
  logic [N_KEYS-1:0] press_q;
  logic              any_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys.key_raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    logic [DW-1:0] db_cnt;
    logic          lvl;
    logic          mismatch;
    logic          settle;

    assign mismatch = sync2[i] ^ lvl;
    assign settle   = mismatch && (db_cnt == DB_LAST);

    // Any cycle of agreement restarts the count, so bounces never accumulate.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        db_cnt <= '0;
        lvl    <= 1'b0;
      end else if (!mismatch) begin
        db_cnt <= '0;
      end else if (settle) begin
        db_cnt <= '0;
        lvl    <= ~lvl;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    assign level[i] = lvl;
    assign rise[i]  = settle & ~lvl;

`ifdef KEY_AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rpt
      typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_PERIOD
      } rpt_state_t;

      rpt_state_t    state;
      rpt_state_t    state_nx;
      logic [RW-1:0] cnt;
      logic [RW-1:0] cnt_nx;
      logic          pulse;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state <= RPT_IDLE;
          cnt   <= '0;
        end else begin
          state <= state_nx;
          cnt   <= cnt_nx;
        end
      end

      // The press edge restarts timing; a release edge wins over a coinciding repeat.
      always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        pulse    = 1'b0;
        if (rise[i]) begin
          state_nx = RPT_DELAY;
          cnt_nx   = '0;
        end else if (!lvl || settle) begin
          state_nx = RPT_IDLE;
          cnt_nx   = '0;
        end else begin
          case (state)
            RPT_DELAY: begin
              if (cnt == DELAY_LAST) begin
                pulse    = 1'b1;
                cnt_nx   = '0;
                state_nx = RPT_PERIOD;
              end
            end
            RPT_PERIOD: begin
              if (cnt == PERIOD_LAST) begin
                pulse  = 1'b1;
                cnt_nx = '0;
              end
            end
            default: begin
              cnt_nx = '0;
            end
          endcase
        end
      end

      assign rpt_pulse[i] = pulse;
    end else begin : g_no_rpt
      assign rpt_pulse[i] = 1'b0;
    end
`else
    assign rpt_pulse[i] = 1'b0;
`endif
  end

  assign press_d = rise | rpt_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q <= '0;
      any_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      any_q   <= |press_d;
    end
  end

  assign keys.key_level = level;
  assign keys.key_press = press_q;
  assign keys.any_press = any_q;
endmodule
